// File: rtl/ps2_key_queue.sv
// PS/2 to Apple //e keyboard front end: keystroke FIFO, held-key tracking for akd,
// typematic auto-repeat and open/closed-apple modifiers. ASCII comes from an external ROM.
module ps2_key_queue #(
  parameter int DEPTH     = 4,
  parameter int NKEY      = 4,
  parameter int REP_DELAY = 7000000,
  parameter int REP_RATE  = 933333
) (
  input  logic                    CLK_14M,
  input  logic                    reset,
  input  logic [10:0]             PS2_Key,
  input  logic                    reads,
  output logic [11:0]             rom_addr,
  input  logic [7:0]              rom_data,
  output logic [7:0]              K,
  output logic                    akd,
  output logic                    open_apple,
  output logic                    closed_apple,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW      = $clog2(DEPTH);
  localparam int REP_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int CW      = $clog2(REP_MAX + 1);

  typedef enum logic [2:0] {IDLE, DECODE, LOOKUP, CAPTURE, RELEASE} state_t;

  state_t          state, state_nx;
  logic            old_stb, primed;
  logic            ev_make, ev_ext;
  logic [7:0]      ev_code;
  logic [8:0]      ev_key;
  logic            shift, ctrl, caplock;
  logic [NKEY-1:0] slot_valid, hit_vec, free_vec;
  logic [8:0]      slot_key [NKEY];
  logic            rep_active;
  logic [8:0]      rep_key;
  logic [6:0]      rep_ascii;
  logic [CW-1:0]   rep_cnt;
  logic [6:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [6:0]      last_pop;

  logic ev_pending, is_shift, is_ctrl, is_alt, is_caps, is_mod;
  logic cap_push, rep_fire, push, do_pop, fifo_full, push_ok;
  logic [6:0] push_data;

  assign ev_key     = {ev_ext, ev_code};
  assign ev_pending = primed && (PS2_Key[10] != old_stb);
  assign is_shift   = (ev_code == 8'h12) || (ev_code == 8'h59);
  assign is_ctrl    = (ev_code == 8'h14);
  assign is_alt     = (ev_code == 8'h11);
  assign is_caps    = (ev_code == 8'h58);
  assign is_mod     = is_shift || is_ctrl || is_alt || is_caps;

  // Held-table match and first free slot.
  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    hit_vec  = '0;
    free_vec = '0;
    for (int i = 0; i < NKEY; i++) begin
      hit_vec[i] = slot_valid[i] && (slot_key[i] == ev_key);
      if (!slot_valid[i] && (free_vec == '0)) free_vec[i] = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ev_pending) state_nx = DECODE;
      DECODE: begin
        if (!ev_make)                 state_nx = RELEASE;
        else if (is_mod || |hit_vec)  state_nx = IDLE;
        else                          state_nx = LOOKUP;
      end
      LOOKUP:  state_nx = CAPTURE;
      CAPTURE: state_nx = IDLE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A fresh keystroke beats a repeat landing on the same cycle.
  assign cap_push  = (state == CAPTURE) && !rom_data[7];
  assign rep_fire  = rep_active && (rep_cnt == '0);
  assign push      = cap_push || rep_fire;
  assign push_data = cap_push ? rom_data[6:0] : rep_ascii;
  assign do_pop    = reads && (fifo_count != '0);
  assign fifo_full = (fifo_count == (AW+1)'(DEPTH));
  assign push_ok   = push && (!fifo_full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      primed  <= 1'b0;
      old_stb <= 1'b0;
      ev_make <= 1'b0;
      ev_ext  <= 1'b0;
      ev_code <= '0;
    end else begin
      primed <= 1'b1;
      if (!primed) begin
        old_stb <= PS2_Key[10];
      end else if (state == IDLE && ev_pending) begin
        old_stb <= PS2_Key[10];
        ev_make <= PS2_Key[9];
        ev_ext  <= PS2_Key[8];
        ev_code <= PS2_Key[7:0];
      end
    end
  end

  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      shift        <= 1'b0;
      ctrl         <= 1'b0;
      caplock      <= 1'b0;
      open_apple   <= 1'b0;
      closed_apple <= 1'b0;
      rom_addr     <= '0;
    end else begin
      if (state == DECODE) begin
        if (is_shift)           shift        <= ev_make;
        if (is_ctrl)            ctrl         <= ev_make;
        if (is_alt && !ev_ext)  open_apple   <= ev_make;
        if (is_alt && ev_ext)   closed_apple <= ev_make;
        if (is_caps && !ev_make) caplock     <= ~caplock;
      end
      rom_addr <= {caplock, ev_ext, ev_code, ~ctrl, ~shift};
    end
  end

  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      for (int i = 0; i < NKEY; i++) slot_key[i] <= '0;
    end else begin
      for (int i = 0; i < NKEY; i++) begin
        if (cap_push && free_vec[i]) begin
          slot_valid[i] <= 1'b1;
          slot_key[i]   <= ev_key;
        end else if (state == RELEASE && hit_vec[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign akd = |slot_valid;

  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      rep_active <= 1'b0;
      rep_key    <= '0;
      rep_ascii  <= '0;
      rep_cnt    <= '0;
    end else if (cap_push) begin
      rep_active <= 1'b1;
      rep_key    <= ev_key;
      rep_ascii  <= rom_data[6:0];
      rep_cnt    <= CW'(REP_DELAY - 1);
    end else if (state == RELEASE && rep_active && rep_key == ev_key) begin
      rep_active <= 1'b0;
    end else if (rep_active) begin
      rep_cnt <= rep_fire ? CW'(REP_RATE - 1) : rep_cnt - CW'(1);
    end
  end

  // NOTE: FIFO storage is not reset; only the pointers and count define which entries are live.
  always_ff @(posedge CLK_14M) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK_14M or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      last_pop   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        last_pop <= mem[rd_ptr];
      end
      if (push_ok && !do_pop)      fifo_count <= fifo_count + (AW+1)'(1);
      else if (!push_ok && do_pop) fifo_count <= fifo_count - (AW+1)'(1);
      if (cap_push && !push_ok) overflow <= 1'b1;
      else if (reads)           overflow <= 1'b0;
    end
  end

  assign K = {fifo_count != '0, (fifo_count != '0) ? mem[rd_ptr] : last_pop};

endmodule

// File: tb/tb_ps2_key_queue.sv
// Directed bench for ps2_key_queue: latency, FIFO overflow/order, typematic repeat,
// modifiers, coincident read/push and reset during a lookup.
module tb_ps2_key_queue;

  logic        CLK_14M;
  logic        reset;
  logic [10:0] PS2_Key;
  logic        reads;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  K;
  logic        akd, open_apple, closed_apple, overflow;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  ps2_key_queue #(.DEPTH(4), .NKEY(4), .REP_DELAY(10), .REP_RATE(4)) dut (
    .CLK_14M(CLK_14M), .reset(reset), .PS2_Key(PS2_Key), .reads(reads),
    .rom_addr(rom_addr), .rom_data(rom_data), .K(K), .akd(akd),
    .open_apple(open_apple), .closed_apple(closed_apple),
    .overflow(overflow), .fifo_count(fifo_count)
  );

  initial CLK_14M = 1'b0;
  always #5 CLK_14M = ~CLK_14M;

  function automatic logic [7:0] rom_fn(input logic [11:0] a);
    case (a[9:2])
      8'h1C:   return 8'h41;
      8'h32:   return 8'h42;
      8'h21:   return 8'h43;
      8'h23:   return 8'h44;
      8'h24:   return 8'h45;
      default: return 8'h80;
    endcase
  endfunction

  // Registered ROM with one cycle of latency.
  always @(posedge CLK_14M) rom_data <= rom_fn(rom_addr);

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_14M);
    #1;
  endtask

  task automatic send(input logic make, input logic ext, input logic [7:0] code);
    PS2_Key = {~PS2_Key[10], make, ext, code};
  endtask

  task automatic pulse_read();
    reads = 1'b1;
    tick(1);
    reads = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  logic [7:0] codes [5];

  initial begin
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    PS2_Key = 11'h400;
    reads   = 1'b0;
    reset   = 1'b1;
    tick(3);
    check("rst_rom_addr", 32'(rom_addr), 'h0);
    check("rst_K", 32'(K), 'h0);
    check("rst_count", 32'(fifo_count), 'h0);
    check("rst_akd", 32'(akd), 'h0);
    check("rst_ovf", 32'(overflow), 'h0);
    reset = 1'b0;
    tick(5);
    check("no_evt_count", 32'(fifo_count), 'h0);
    check("no_evt_K", 32'(K), 'h0);
    check("no_evt_akd", 32'(akd), 'h0);

    // Single keystroke: latency, read, break.
    send(1'b1, 1'b0, 8'h1C);
    tick(3);
    check("lat3_K7", 32'(K[7]), 'h0);
    tick(1);
    check("make_A_K", 32'(K), 'hC1);
    check("make_A_akd", 32'(akd), 'h1);
    pulse_read();
    check("read_A_K", 32'(K), 'h41);
    check("read_A_count", 32'(fifo_count), 'h0);
    send(1'b0, 1'b0, 8'h1C);
    tick(3);
    check("brk_A_akd", 32'(akd), 'h0);
    tick(15);
    check("brk_A_norep", 32'(fifo_count), 'h0);

    // Five presses into a four-entry FIFO.
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b0, codes[i]);
      tick(4);
    end
    check("ovf_count", 32'(fifo_count), 'h4);
    check("ovf_flag", 32'(overflow), 'h1);
    check("ovf_head", 32'(K), 'hC1);
    check("ovf_akd", 32'(akd), 'h1);
    for (int i = 4; i >= 0; i--) begin
      send(1'b0, 1'b0, codes[i]);
      tick(3);
    end
    check("ovf_brk_akd", 32'(akd), 'h0);
    check("ovf_brk_count", 32'(fifo_count), 'h4);
    for (int i = 0; i < 4; i++) begin
      check("ovf_order", 32'(K), 32'(8'hC1 + i));
      pulse_read();
      if (i == 0) check("ovf_clear", 32'(overflow), 'h0);
    end
    check("ovf_drain_count", 32'(fifo_count), 'h0);
    check("ovf_drain_K", 32'(K), 'h44);

    // Auto-repeat: pushes 10, 14, 18 cycles after capture; keyboard duplicates ignored.
    send(1'b1, 1'b0, 8'h1C);
    tick(4);
    check("rep_c0", 32'(fifo_count), 'h1);
    tick(1);
    send(1'b1, 1'b0, 8'h1C);
    tick(4);
    send(1'b1, 1'b0, 8'h1C);
    tick(4);
    check("rep_c9", 32'(fifo_count), 'h1);
    tick(1);
    check("rep_c10", 32'(fifo_count), 'h2);
    check("rep_c10_K", 32'(K), 'hC1);
    pulse_read();
    check("rep_c11", 32'(fifo_count), 'h1);
    tick(2);
    check("rep_c13", 32'(fifo_count), 'h1);
    tick(1);
    check("rep_c14", 32'(fifo_count), 'h2);
    tick(3);
    check("rep_c17", 32'(fifo_count), 'h2);
    tick(1);
    check("rep_c18", 32'(fifo_count), 'h3);
    send(1'b0, 1'b0, 8'h1C);
    tick(8);
    check("rep_stopped", 32'(fifo_count), 'h3);
    check("rep_akd", 32'(akd), 'h0);
    for (int i = 0; i < 3; i++) pulse_read();
    check("rep_drain", 32'(fifo_count), 'h0);

    // Modifiers and ROM address formation.
    send(1'b1, 1'b0, 8'h12);
    tick(2);
    send(1'b1, 1'b0, 8'h1C);
    tick(2);
    check("shift_addr_lo", 32'(rom_addr[1:0]), 'h2);
    check("shift_addr_code", 32'(rom_addr[9:2]), 'h1C);
    tick(2);
    send(1'b0, 1'b0, 8'h1C);
    tick(3);
    pulse_read();
    send(1'b0, 1'b0, 8'h12);
    tick(3);
    send(1'b1, 1'b0, 8'h14);
    tick(3);
    check("ctrl_addr_lo", 32'(rom_addr[1:0]), 'h1);
    send(1'b0, 1'b0, 8'h14);
    tick(3);
    send(1'b1, 1'b0, 8'h58);
    tick(3);
    check("caps_make_addr", 32'(rom_addr[11]), 'h0);
    send(1'b0, 1'b0, 8'h58);
    tick(3);
    check("caps_brk_addr", 32'(rom_addr[11]), 'h1);
    send(1'b1, 1'b1, 8'h11);
    tick(2);
    check("ralt_closed", 32'(closed_apple), 'h1);
    check("ralt_open", 32'(open_apple), 'h0);
    tick(1);
    check("ralt_count", 32'(fifo_count), 'h0);
    check("ralt_akd", 32'(akd), 'h0);
    send(1'b1, 1'b0, 8'h11);
    tick(3);
    check("lalt_open", 32'(open_apple), 'h1);
    send(1'b0, 1'b1, 8'h11);
    tick(3);
    send(1'b0, 1'b0, 8'h11);
    tick(3);
    check("alt_brk", 32'({open_apple, closed_apple}), 'h0);

    // Read strobe on the same cycle as a capture push.
    send(1'b1, 1'b0, 8'h32);
    tick(4);
    send(1'b0, 1'b0, 8'h32);
    tick(3);
    send(1'b1, 1'b0, 8'h21);
    tick(4);
    send(1'b0, 1'b0, 8'h21);
    tick(3);
    check("coinc_pre_count", 32'(fifo_count), 'h2);
    check("coinc_pre_K", 32'(K), 'hC2);
    send(1'b1, 1'b0, 8'h23);
    tick(3);
    reads = 1'b1;
    tick(1);
    reads = 1'b0;
    check("coinc_count", 32'(fifo_count), 'h2);
    check("coinc_K", 32'(K), 'hC3);
    send(1'b0, 1'b0, 8'h23);
    tick(3);
    pulse_read();
    pulse_read();
    check("coinc_drain_K", 32'(K), 'h44);

    // Reset asserted while the FSM is in LOOKUP.
    send(1'b1, 1'b0, 8'h24);
    tick(2);
    reset = 1'b1;
    #1;
    check("lk_rst_count", 32'(fifo_count), 'h0);
    check("lk_rst_K", 32'(K), 'h0);
    check("lk_rst_addr", 32'(rom_addr), 'h0);
    tick(2);
    reset = 1'b0;
    tick(8);
    check("lk_post_count", 32'(fifo_count), 'h0);
    check("lk_post_akd", 32'(akd), 'h0);
    send(1'b1, 1'b0, 8'h1C);
    tick(4);
    check("lk_post_make_K", 32'(K), 'hC1);
    send(1'b0, 1'b0, 8'h1C);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_queue.md
Name: ps2_key_queue

Overview:
- Parametrised PS/2-to-Apple //e keyboard front end for the Apple II core.
- Buffers decoded keystrokes in a DEPTH-entry FIFO, so fast typing is not lost between CPU reads of $C000/$C010.
- Tracks up to NKEY simultaneously held keys for any-key-down (akd), with programmable typematic delay/rate and open-apple/closed-apple modifier outputs.
- Translation uses an external registered ROM addressed directly by full scan code, so no internal junction table is needed.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
NKEY, 4, held-key tracking slots, minimum 1
REP_DELAY, 7000000, CLK_14M cycles before first auto-repeat (0.5 s)
REP_RATE, 933333, CLK_14M cycles between subsequent repeats (1/15 s)

Ports:
CLK_14M  in  1  system clock
reset  in  1  reset, asynchronous, active-high
PS2_Key  in  11  [10] event toggle, [9] 1=make/0=break, [8] extended, [7:0] scan code
reads  in  1  one-cycle $C010 strobe-clear pulse
rom_addr  out  12  {caplock, ext, code[7:0], ~ctrl, ~shift}
rom_data  in  8  registered ROM output, 1-cycle latency; bit7=1 means no key, [6:0] ASCII
K  out  8  {fifo_not_empty, head_ascii[6:0]}
akd  out  1  any tracked non-modifier key held
open_apple  out  1  left Alt (0x11, ext=0) held
closed_apple  out  1  right Alt (0x11, ext=1) held
overflow  out  1  sticky, set when a press is dropped because the FIFO is full
fifo_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset: all outputs, modifiers (shift, ctrl, caplock, apples), held table, FIFO pointers, repeat state, rom_addr and the FSM go to 0/IDLE. This applies mid-operation too; an in-flight event is discarded.
- First cycle after reset: old_stb samples PS2_Key[10]. No event is generated on that cycle.
- Event detect: an event is taken in IDLE when PS2_Key[10] != old_stb. old_stb updates when the event is accepted. A toggle arriving while the FSM is busy is serviced on return to IDLE.
- FSM states: IDLE -> DECODE -> one of the paths below.
  - Break path: DECODE -> RELEASE -> IDLE.
  - Modifier make path: DECODE -> IDLE, updating the modifier.
  - Other make path: DECODE -> LOOKUP -> CAPTURE -> IDLE.
- Modifier codes: 0x12/0x59 shift; 0x14 (either ext) ctrl; 0x11 open/closed apple by ext; 0x58 caps lock.
  - Shift, ctrl and apples are set on make and cleared on break.
  - caplock toggles on break only.
  - Modifiers never enter the FIFO or the held table.
- LOOKUP: rom_addr is driven from the latched event and current modifiers. rom_data is sampled in CAPTURE.
- CAPTURE, with rom_data[7]=0:
  - Push rom_data[6:0] to the FIFO.
  - Insert {ext,code} into a free held slot.
  - Set the repeat key to this key and its ASCII; load the repeat counter with REP_DELAY.
  - If rom_data[7]=1, nothing happens.
- Duplicate make (the PS/2 keyboard's own typematic) for a key already in the held table: ignored in DECODE; return to IDLE with no lookup and no push.
- Held table full: the key is still pushed and becomes the repeat key, but is not tracked; its break is ignored.
- RELEASE: clear the matching slot. If it is the repeat key, repeat stops and does not resume for other held keys.
- akd = OR of slot valid bits, updated the cycle after insert/remove.
- Repeat counter: decrements each cycle while repeat is active. At 0 it pushes the stored ASCII and reloads REP_RATE.
  - A repeat push with the FIFO full is silently dropped; overflow is not set.
  - A repeat push coinciding with a CAPTURE push: the CAPTURE push wins and the counter reloads to REP_DELAY.
- FIFO rules:
  - A push when full is dropped and sets overflow.
  - reads when not empty pops.
  - Simultaneous push and pop when full or non-empty: both occur and the count is unchanged.
  - reads when empty has no effect.
  - reads clears overflow.
- K[7] = fifo_count != 0. K[6:0] = head entry; when empty, K[6:0] holds the last popped value.
- Pointers wrap modulo DEPTH.
- Latency: from the accepted toggle to K[7] rising is 4 cycles (DECODE, LOOKUP, CAPTURE, registered FIFO update).

Test Plan:
- Reset with PS2_Key[10]=1, release -> no event; K=0x00, akd=0, fifo_count=0.
- Make 'A' (0x1C), ROM returns 0x41 -> K=0xC1 4 cycles after toggle, akd=1; reads -> K=0x41; break -> akd=0.
- Five presses with no reads, DEPTH=4 -> fifo_count=4, overflow=1, fifth dropped; four reads return the keys in order; the first read clears overflow.
- Hold 'A' with REP_DELAY=10, REP_RATE=4 -> pushes at 10, 14, 18 cycles after capture; duplicate makes from the keyboard add nothing; break stops the pushes.
- Shift make, 0x1C make -> rom_addr[1:0]=2'b10; caps make+break -> rom_addr[11] toggles to 1; right Alt make (ext=1, 0x11) -> closed_apple=1, no FIFO change.
- reads pulse on the same cycle as a CAPTURE push with fifo_count=2 -> fifo_count stays 2, head advances; assert reset during LOOKUP -> FSM IDLE, no push.
